ccu_snoop_responder: RTL and testbench
======================================

// Module: ccu_snoop_responder
// PURPOSE
//  Snoop responder on the cached-master side of the ACE snoop interface, i.e. the far end of the CCU
//  snoop initiator. It accepts one AC request at a time and looks up the local cache tag array.
//  It returns the CR response, streams dirty/shared line data on CD from the data array, and issues
//  a tag-state update. Sits between the CCU snoop crossbar port and a private L1 cache.
// PARAMETERS
//  ADDR_WIDTH   64  AC address width
//  DATA_WIDTH   64  CD beat width
//  CD_BEATS     4   beats per cache line (line = CD_BEATS*DATA_WIDTH/8 bytes); power of 2, >=2
// PORTS
//  clk_i          in   1           clock
//  rst_i          in   1           reset, synchronous, active-high
//  ac_valid_i     in   1           snoop request valid
//  ac_ready_o     out  1           snoop request ready
//  ac_addr_i      in   ADDR_WIDTH  snoop address
//  ac_snoop_i     in   4           AC snoop opcode (acsnoop_t encoding)
//  cr_valid_o     out  1           snoop response valid
//  cr_ready_i     in   1           snoop response ready
//  cr_resp_o      out  5           {WasUnique,IsShared,PassDirty,Error,DataTransfer}, bit0=DataTransfer
//  cd_valid_o     out  1           snoop data valid
//  cd_ready_i     in   1           snoop data ready
//  cd_data_o      out  DATA_WIDTH  snoop data beat
//  cd_last_o      out  1           last beat of line
//  tag_req_o      out  1           tag lookup request; held until tag_gnt_i
//  tag_gnt_i      in   1           tag lookup granted; result valid exactly 1 cycle later
//  tag_addr_o     out  ADDR_WIDTH  line-aligned lookup/update address
//  tag_hit_i      in   1           result: line present
//  tag_dirty_i    in   1           result: line dirty
//  tag_unique_i   in   1           result: line unique
//  upd_valid_o    out  1           one-cycle tag-state update strobe
//  upd_state_o    out  2           new state: 00 Invalid, 01 SharedClean, 10 UniqueClean
//  data_req_o     out  1           data-array read request (always accepted)
//  data_beat_o    out  log2(CD_BEATS) beat index; data_rdata_i valid exactly 1 cycle after request
//  data_rdata_i   in   DATA_WIDTH  read data
// BEHAVIOUR
//  Reset: FSM=IDLE; ac_ready_o=1; cr_valid_o, cd_valid_o, tag_req_o, upd_valid_o, data_req_o=0;
//   cr_resp_o=0; beat counters=0; CD buffer empty. Reset mid-operation aborts the snoop; returned read data is discarded.
//  FSM: IDLE -ac hs-> LOOKUP -tag_gnt-> WAIT (1 cyc, capture result) -> RESP -cr hs-> DATA if DT else IDLE;
//   DATA -> IDLE on CD handshake with cd_last_o=1.
//  ac_ready_o=1 only in IDLE. addr, opcode, result latched; tag_addr_o=addr with low log2(line bytes) bits cleared.
//  cr_valid_o asserted in RESP and stable until cr_ready_i; cr_resp_o constant in RESP. Error bit always 0.
//  upd_valid_o pulses on the CR handshake cycle iff hit and the rule below changes state.
//  Rules (miss => cr_resp_o=0, no CD, no update, any opcode). WU=tag_unique_i for every hit:
//   ReadOnce 0000: DT=1 IS=1 PD=0; no update
//   ReadShared 0001, ReadClean 0010, ReadNotSharedDirty 0011: DT=1 IS=1 PD=dirty; -> SharedClean
//   ReadUnique 0111: DT=1 IS=0 PD=dirty; -> Invalid
//   CleanInvalid 1001: DT=dirty PD=dirty IS=0; -> Invalid
//   CleanShared 1000: DT=dirty PD=dirty IS=1; dirty -> UniqueClean if unique else SharedClean; clean: no update
//   MakeInvalid 1101: DT=0 IS=0; -> Invalid
//   any other opcode: cr_resp_o=0; no CD; no update
//  DATA: reads beats 0..CD_BEATS-1 in order into a 2-entry CD FIFO.
//   data_req_o only if occupancy + in-flight < 2 and beats remain.
//   Full throughput: 1 beat/cycle with cd_ready_i held high.
//  cd_last_o=1 exactly on beat CD_BEATS-1. CD FIFO never overflows. cd_valid_o/cd_data_o stable under backpressure.
//  Line read starts on the CR handshake cycle, so the first beat leaves 2 cycles after the CR handshake.
//  A new AC is not accepted until the last CD beat is handshaken (one outstanding snoop).
// TESTING
//  Miss, ReadShared 0x1000 -> cr_resp_o=0, no CD, no upd, back to IDLE 1 cycle after cr hs
//  Hit dirty unique, ReadUnique, data beats A0..A3 -> cr_resp_o=5'b10101; CD A0..A3, last on A3; upd=Invalid
//  Hit clean shared, ReadShared with cd_ready_i toggling 1/0 -> cr=5'b01001; 4 beats in order, none lost/duplicated
//  Hit clean unique, CleanInvalid -> cr=5'b10000, no CD, upd=Invalid; MakeInvalid same state -> cr=5'b10000
//  tag_gnt_i low 5 cycles, cr_ready_i low 3 cycles -> tag_req_o/cr_valid_o held; ac_ready_o=0 throughout
//  rst_i asserted during beat 2 of DATA -> next cycle all valids 0, ac_ready_o=1; next snoop responds correctly

Source files
------------

// File: rtl/ccu_snoop_responder_if.sv
// Snoop-side bundle of the cached master: ACE AC/CR/CD channels plus the local tag and data array ports.
// Signal directions in the names are seen from the responder (slave modport).
interface ccu_snoop_responder_if #(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64,
  parameter int CD_BEATS   = 4
);
  localparam int BEAT_W = $clog2(CD_BEATS);

  logic                  ac_valid_i;
  logic                  ac_ready_o;
  logic [ADDR_WIDTH-1:0] ac_addr_i;
  logic [3:0]            ac_snoop_i;
  logic                  cr_valid_o;
  logic                  cr_ready_i;
  logic [4:0]            cr_resp_o;
  logic                  cd_valid_o;
  logic                  cd_ready_i;
  logic [DATA_WIDTH-1:0] cd_data_o;
  logic                  cd_last_o;
  logic                  tag_req_o;
  logic                  tag_gnt_i;
  logic [ADDR_WIDTH-1:0] tag_addr_o;
  logic                  tag_hit_i;
  logic                  tag_dirty_i;
  logic                  tag_unique_i;
  logic                  upd_valid_o;
  logic [1:0]            upd_state_o;
  logic                  data_req_o;
  logic [BEAT_W-1:0]     data_beat_o;
  logic [DATA_WIDTH-1:0] data_rdata_i;

  modport slave (
    input  ac_valid_i, ac_addr_i, ac_snoop_i, cr_ready_i, cd_ready_i,
           tag_gnt_i, tag_hit_i, tag_dirty_i, tag_unique_i, data_rdata_i,
    output ac_ready_o, cr_valid_o, cr_resp_o, cd_valid_o, cd_data_o, cd_last_o,
           tag_req_o, tag_addr_o, upd_valid_o, upd_state_o, data_req_o, data_beat_o
  );

  modport master (
    output ac_valid_i, ac_addr_i, ac_snoop_i, cr_ready_i, cd_ready_i,
           tag_gnt_i, tag_hit_i, tag_dirty_i, tag_unique_i, data_rdata_i,
    input  ac_ready_o, cr_valid_o, cr_resp_o, cd_valid_o, cd_data_o, cd_last_o,
           tag_req_o, tag_addr_o, upd_valid_o, upd_state_o, data_req_o, data_beat_o
  );
endinterface

// File: rtl/ccu_snoop_responder.sv
// ACE snoop responder for a private L1: one snoop at a time, tag lookup, CR response,
// tag-state update and a line stream on CD through a 2-entry buffer.
module ccu_snoop_responder #(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64,
  parameter int CD_BEATS   = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  ccu_snoop_responder_if.slave   bus
);
  localparam int BEAT_W = $clog2(CD_BEATS);
  localparam int OFF_W  = $clog2(CD_BEATS * DATA_WIDTH / 8);
  localparam logic [1:0] ST_INV = 2'b00;
  localparam logic [1:0] ST_SC  = 2'b01;
  localparam logic [1:0] ST_UC  = 2'b10;

  typedef enum logic [2:0] {S_IDLE, S_LOOKUP, S_WAIT, S_RESP, S_DATA} state_t;
  state_t r_state, w_state_nxt;

  logic [ADDR_WIDTH-1:0] r_addr;
  logic [3:0]            r_snoop;
  logic [4:0]            r_resp;
  logic                  r_upd_en;
  logic [1:0]            r_upd_state;
  logic [BEAT_W:0]       r_req_cnt;
  logic [BEAT_W-1:0]     r_pop_cnt;
  logic                  r_inflight;
  logic [DATA_WIDTH-1:0] r_fifo [2];
  logic                  r_wptr, r_rptr;
  logic [1:0]            r_occ;

  logic w_ac_ready, w_tag_req, w_cr_valid, w_upd_valid;
  logic w_pop, w_last, w_line_rd, w_data_req;

  // Returns {update enable, new state, cr_resp}; update enable only when the state actually changes.
  function automatic logic [7:0] snoop_rule(input logic [3:0] op, input logic hit,
                                            input logic dirty, input logic uniq);
    logic dt, shd, pd, en;
    logic [1:0] st;
    dt = 1'b0; shd = 1'b0; pd = 1'b0; en = 1'b0; st = ST_INV;
    case (op)
      4'b0000: begin dt = 1'b1; shd = 1'b1; end
      4'b0001, 4'b0010, 4'b0011: begin
        dt = 1'b1; shd = 1'b1; pd = dirty; en = dirty | uniq; st = ST_SC;
      end
      4'b0111: begin dt = 1'b1; pd = dirty; en = 1'b1; end
      4'b1001: begin dt = dirty; pd = dirty; en = 1'b1; end
      4'b1000: begin
        dt = dirty; pd = dirty; shd = 1'b1; en = dirty; st = uniq ? ST_UC : ST_SC;
      end
      4'b1101: en = 1'b1;
      default: return 8'h00;
    endcase
    if (!hit) return 8'h00;
    return {en, st, uniq, shd, pd, 1'b0, dt};
  endfunction

  always_comb begin
    w_state_nxt = r_state;
    w_ac_ready  = 1'b0;
    w_tag_req   = 1'b0;
    w_cr_valid  = 1'b0;
    w_upd_valid = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_ac_ready = 1'b1;
        if (bus.ac_valid_i) w_state_nxt = S_LOOKUP;
      end
      S_LOOKUP: begin
        w_tag_req = 1'b1;
        if (bus.tag_gnt_i) w_state_nxt = S_WAIT;
      end
      S_WAIT: w_state_nxt = S_RESP;
      S_RESP: begin
        w_cr_valid = 1'b1;
        if (bus.cr_ready_i) begin
          w_upd_valid = r_upd_en;
          w_state_nxt = r_resp[0] ? S_DATA : S_IDLE;
        end
      end
      S_DATA: if (w_pop && w_last) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Counting the beat leaving this cycle as free space keeps 1 beat/cycle with a 2-deep buffer.
  assign w_pop      = (r_occ != 2'd0) && bus.cd_ready_i;
  assign w_last     = &r_pop_cnt;
  assign w_line_rd  = (r_state == S_DATA) || ((r_state == S_RESP) && bus.cr_ready_i && r_resp[0]);
  assign w_data_req = w_line_rd && (r_req_cnt < (BEAT_W+1)'(CD_BEATS)) &&
                      (({1'b0, r_occ} + {2'b00, r_inflight} - {2'b00, w_pop}) < 3'd2);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= S_IDLE;
      r_resp      <= 5'd0;
      r_upd_en    <= 1'b0;
      r_upd_state <= ST_INV;
      r_req_cnt   <= '0;
      r_pop_cnt   <= '0;
      r_inflight  <= 1'b0;
      r_occ       <= 2'd0;
      r_wptr      <= 1'b0;
      r_rptr      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_inflight <= w_data_req;
      r_occ      <= r_occ + {1'b0, r_inflight} - {1'b0, w_pop};
      if (r_state == S_WAIT)
        {r_upd_en, r_upd_state, r_resp} <= snoop_rule(r_snoop, bus.tag_hit_i,
                                                      bus.tag_dirty_i, bus.tag_unique_i);
      if (r_inflight) r_wptr <= ~r_wptr;
      if (w_pop) begin
        r_rptr    <= ~r_rptr;
        r_pop_cnt <= r_pop_cnt + 1'b1;
      end
      if (r_state == S_IDLE) begin
        r_req_cnt <= '0;
        r_pop_cnt <= '0;
      end else if (w_data_req) begin
        r_req_cnt <= r_req_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_ac_ready && bus.ac_valid_i) begin
      r_addr  <= bus.ac_addr_i;
      r_snoop <= bus.ac_snoop_i;
    end
    if (r_inflight) r_fifo[r_wptr] <= bus.data_rdata_i;
  end

  assign bus.ac_ready_o  = w_ac_ready;
  assign bus.cr_valid_o  = w_cr_valid;
  assign bus.cr_resp_o   = r_resp;
  assign bus.cd_valid_o  = (r_occ != 2'd0);
  assign bus.cd_data_o   = r_fifo[r_rptr];
  assign bus.cd_last_o   = w_last;
  assign bus.tag_req_o   = w_tag_req;
  assign bus.tag_addr_o  = {r_addr[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}};
  assign bus.upd_valid_o = w_upd_valid;
  assign bus.upd_state_o = r_upd_state;
  assign bus.data_req_o  = w_data_req;
  assign bus.data_beat_o = r_req_cnt[BEAT_W-1:0];
endmodule

// File: tb/tb_ccu_snoop_responder.sv
// Randomized bench for ccu_snoop_responder against a cache-state reference model.
module tb_ccu_snoop_responder;
  localparam int CD_BEATS   = 4;
  localparam int LINE_BYTES = CD_BEATS * 64 / 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  ccu_snoop_responder_if bus ();
  ccu_snoop_responder dut (.clk_i(clk), .rst_i(rst), .bus(bus.slave));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Cache line states: 0 Invalid, 1 SharedClean, 2 UniqueClean; dirty tracked separately.
  task automatic ref_model(input logic [3:0] op, input bit h, input bit d, input bit u,
                           output logic [4:0] resp, output bit upd, output logic [1:0] st);
    bit known = 1, retarget = 0, dt = 0, shd = 0, pd = 0;
    int old_s = u ? 2 : 1;
    int new_s = old_s;
    case (op)
      4'd0:             begin dt = 1; shd = 1; end
      4'd1, 4'd2, 4'd3: begin dt = 1; shd = 1; pd = d; new_s = 1; retarget = 1; end
      4'd7:             begin dt = 1; pd = d; new_s = 0; retarget = 1; end
      4'd9:             begin dt = d; pd = d; new_s = 0; retarget = 1; end
      4'd8:             begin dt = d; pd = d; shd = 1; retarget = d; end
      4'd13:            begin new_s = 0; retarget = 1; end
      default:          known = 0;
    endcase
    if (!h || !known) begin
      resp = 5'd0; upd = 0; st = 2'd0;
    end else begin
      resp = {u, shd, pd, 1'b0, dt};
      upd  = retarget && ((new_s != old_s) || d);
      st   = 2'(new_s);
    end
  endtask

  task automatic do_snoop(input logic [3:0] op, input logic [63:0] addr, input bit h,
                          input bit d, input bit u, input int gnt_dly, input int cr_dly,
                          input int cd_mode, input int rst_beat);
    logic [4:0]  e_resp;
    bit          e_upd;
    logic [1:0]  e_st;
    logic [63:0] line [CD_BEATS];
    logic [63:0] got_d [$];
    bit          got_l [$];
    logic [63:0] cd_prev_d;
    logic [4:0]  cr_prev;
    logic [1:0]  prev_beat = 0;
    bit prev_gnt = 0, prev_req = 0, cd_tog = 0, cd_prev_l = 0;
    bit gnt_pend = 0, cr_pend = 0, cd_pend = 0, tag_seen = 0, cd_seen = 0, fin_pend = 0;
    bit ended = 0, aborted = 0, ready_err = 0, hold_err = 0, stable_err = 0, upd_stray = 0;
    int cyc = 0, cr_cyc = -100, gnt_cnt = 0, cr_cnt = 0, rst_ph = 0;

    ref_model(op, h, d, u, e_resp, e_upd, e_st);
    for (int i = 0; i < CD_BEATS; i++) line[i] = {$urandom, $urandom};

    @(posedge clk); #1;
    bus.ac_valid_i = 1'b1; bus.ac_addr_i = addr; bus.ac_snoop_i = op;
    @(negedge clk);
    chk("ac_ready_idle", bus.ac_ready_o, 1);

    while (cyc < 300) begin
      @(posedge clk); #1;
      bus.ac_valid_i = 1'b0;
      bus.ac_addr_i  = {$urandom, $urandom};
      bus.ac_snoop_i = 4'($urandom);
      {bus.tag_hit_i, bus.tag_dirty_i, bus.tag_unique_i} = prev_gnt ? {h, d, u} : 3'($urandom);
      bus.data_rdata_i = prev_req ? line[prev_beat] : {$urandom, $urandom};
      if (bus.tag_req_o && gnt_cnt < gnt_dly) begin gnt_cnt++; bus.tag_gnt_i = 1'b0; end
      else bus.tag_gnt_i = bus.tag_req_o;
      if (bus.cr_valid_o && cr_cnt < cr_dly) begin cr_cnt++; bus.cr_ready_i = 1'b0; end
      else bus.cr_ready_i = bus.cr_valid_o;
      case (cd_mode)
        0:       bus.cd_ready_i = 1'b1;
        1:       begin cd_tog = ~cd_tog; bus.cd_ready_i = cd_tog; end
        default: bus.cd_ready_i = 1'($urandom);
      endcase
      if (rst_ph == 1) begin rst = 1'b1; rst_ph = 2; end
      else if (rst_ph == 2) begin rst = 1'b0; rst_ph = 3; end

      @(negedge clk);
      cyc++;
      if (rst_ph == 3) begin
        chk("abort_state", {bus.ac_ready_o, bus.cr_valid_o, bus.cd_valid_o, bus.tag_req_o,
                            bus.upd_valid_o, bus.data_req_o}, 6'b100000);
        aborted = 1;
        break;
      end
      if (rst_ph == 2) continue;
      prev_gnt  = bus.tag_req_o && bus.tag_gnt_i;
      prev_req  = bus.data_req_o;
      prev_beat = bus.data_beat_o;
      if (fin_pend) begin
        chk("idle_after", bus.ac_ready_o, 1);
        ended = 1;
        break;
      end
      if (bus.ac_ready_o) ready_err = 1;
      if (bus.tag_req_o && !tag_seen) begin
        tag_seen = 1;
        chk("tag_addr", bus.tag_addr_o, addr & ~64'(LINE_BYTES - 1));
      end
      if (gnt_pend && !bus.tag_req_o) hold_err = 1;
      gnt_pend = bus.tag_req_o && !bus.tag_gnt_i;
      if (cr_pend && (!bus.cr_valid_o || bus.cr_resp_o !== cr_prev)) hold_err = 1;
      cr_pend = bus.cr_valid_o && !bus.cr_ready_i;
      cr_prev = bus.cr_resp_o;
      if (cd_pend && (!bus.cd_valid_o || bus.cd_data_o !== cd_prev_d || bus.cd_last_o !== cd_prev_l))
        stable_err = 1;
      cd_pend   = bus.cd_valid_o && !bus.cd_ready_i;
      cd_prev_d = bus.cd_data_o;
      cd_prev_l = bus.cd_last_o;
      if (bus.cr_valid_o && bus.cr_ready_i) begin
        chk("cr_resp", bus.cr_resp_o, e_resp);
        chk("upd_valid", bus.upd_valid_o, e_upd);
        if (e_upd) chk("upd_state", bus.upd_state_o, e_st);
        cr_cyc = cyc;
        if (!e_resp[0]) fin_pend = 1;
      end else if (bus.upd_valid_o) begin
        upd_stray = 1;
      end
      if (bus.cd_valid_o && !cd_seen) begin
        cd_seen = 1;
        chk("cd_latency", 64'(cyc - cr_cyc), 64'd2);
      end
      if (bus.cd_valid_o && bus.cd_ready_i) begin
        got_d.push_back(bus.cd_data_o);
        got_l.push_back(bus.cd_last_o);
        if (bus.cd_last_o) fin_pend = 1;
        if (got_d.size() == rst_beat) rst_ph = 1;
      end
    end

    if (!ended && !aborted) chk("timeout", 1, 0);
    if (ended) begin
      chk("n_beats", got_d.size(), e_resp[0] ? CD_BEATS : 0);
      for (int i = 0; i < got_d.size() && i < CD_BEATS; i++) begin
        chk("cd_data", got_d[i], line[i]);
        chk("cd_last", got_l[i], i == CD_BEATS - 1);
      end
      chk("busy_ready", ready_err, 0);
      chk("hold", hold_err, 0);
      chk("cd_stable", stable_err, 0);
      chk("upd_stray", upd_stray, 0);
    end
  endtask

  initial begin
    logic [3:0] op_tab [8];
    logic [3:0] op;
    op_tab = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd7, 4'd8, 4'd9, 4'd13};
    bus.ac_valid_i = 0; bus.ac_addr_i = 0; bus.ac_snoop_i = 0;
    bus.cr_ready_i = 0; bus.cd_ready_i = 0; bus.tag_gnt_i = 0;
    bus.tag_hit_i = 0; bus.tag_dirty_i = 0; bus.tag_unique_i = 0; bus.data_rdata_i = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_state", {bus.ac_ready_o, bus.cr_valid_o, bus.cd_valid_o, bus.tag_req_o,
                        bus.upd_valid_o, bus.data_req_o}, 6'b100000);
    chk("reset_resp", bus.cr_resp_o, 0);

    do_snoop(4'd1,  64'h1000,           0, 0, 0, 0, 0, 0, 0);  // miss
    do_snoop(4'd7,  64'h2345_6789_abcd, 1, 1, 1, 0, 0, 0, 0);  // ReadUnique dirty unique
    do_snoop(4'd1,  64'h40,             1, 0, 0, 0, 0, 1, 0);  // ReadShared, toggling ready
    do_snoop(4'd9,  64'h8000_0000_001f, 1, 0, 1, 0, 0, 0, 0);  // CleanInvalid clean unique
    do_snoop(4'd13, 64'h8000_0000_0020, 1, 0, 1, 0, 0, 0, 0);  // MakeInvalid clean unique
    do_snoop(4'd2,  64'h3000,           1, 1, 0, 5, 3, 0, 0);  // stalled grant and response
    do_snoop(4'd7,  64'h5000,           1, 1, 1, 0, 0, 0, 2);  // reset during beat 2
    do_snoop(4'd3,  64'h6000,           1, 1, 0, 1, 1, 0, 0);

    for (int n = 0; n < 40; n++) begin
      op = ($urandom_range(0, 4) == 0) ? 4'($urandom) : op_tab[$urandom_range(0, 7)];
      do_snoop(op, {$urandom, $urandom}, 1'($urandom_range(0, 3) != 0), 1'($urandom),
               1'($urandom), $urandom_range(0, 3), $urandom_range(0, 3),
               $urandom_range(0, 2), 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
